// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw controller inputs and conditioned event outputs.
// master drives the raw pins and consumes the pulses; slave is the conditioner.
interface input_conditioner_if;
  logic btn_start;
  logic btn_stop;
  logic sensor_n;
  logic start;
  logic stop;
  logic goal;
  logic goal_busy;
  logic beam_blocked;

  modport master (
    output btn_start, btn_stop, sensor_n,
    input  start, stop, goal, goal_busy, beam_blocked
  );

  modport slave (
    input  btn_start, btn_stop, sensor_n,
    output start, stop, goal, goal_busy, beam_blocked
  );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and edge-detects the start/stop
// buttons and the IR goal beam, producing single-cycle start/stop/goal pulses.
// Optional feature macro GOAL_LOCKOUT_EN: when defined, a lockout counter
// suppresses further goals for LOCKOUT_CYCLES after an accepted goal and
// drives goal_busy; when undefined, every debounced beam block is a goal and
// goal_busy is tied low.
module input_conditioner #(
  parameter int DEB_CYCLES     = 1_000_000,
  parameter int LOCKOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 26
) (
  input logic                  clk,
  input logic                  rst,
  input_conditioner_if.slave   bus
);

  // Channel order: 0 = start button, 1 = stop button, 2 = beam (raw is sensor_n).
  // IDLE_LEVEL is the raw pin level when the channel is inactive.
  localparam logic [2:0] IDLE_LEVEL = 3'b100;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [2:0] raw_in;
  logic [2:0] deb_level;
  logic [2:0] deb_prev;
  logic [2:0] rise;
  logic       start_q;
  logic       stop_q;
  logic       goal_q;

  assign raw_in = {bus.sensor_n, bus.btn_stop, bus.btn_start};

  for (genvar i = 0; i < 3; i++) begin : g_chan
    logic             sync1;
    logic             sync2;
    logic             active;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser, resetting to the pin's idle level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1 <= IDLE_LEVEL[i];
        sync2 <= IDLE_LEVEL[i];
      end else begin
        sync1 <= raw_in[i];
        sync2 <= sync1;
      end
    end

    assign active = sync2 ^ IDLE_LEVEL[i];

    // Debounce: the level flips only after DEB_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (active == level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        level <= active;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb_level[i] = level;
  end

  // Previous debounced levels, used to find 0->1 transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_prev <= 3'b000;
    end else begin
      deb_prev <= deb_level;
    end
  end

  assign rise = deb_level & ~deb_prev;

  // Registered button pulses; only presses (rising debounced level) fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= rise[0];
      stop_q  <= rise[1];
    end
  end

`ifdef GOAL_LOCKOUT_EN
  logic [CNT_W-1:0] lock_cnt;

  // Goal pulse with lockout: an accepted goal loads the window, which counts
  // down to zero; beam edges arriving while it runs are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      goal_q   <= 1'b0;
    end else begin
      goal_q <= 1'b0;
      if (lock_cnt != '0) begin
        lock_cnt <= lock_cnt - 1'b1;
      end else if (rise[2]) begin
        goal_q   <= 1'b1;
        lock_cnt <= CNT_W'(LOCKOUT_CYCLES);
      end
    end
  end

  assign bus.goal_busy = (lock_cnt != '0);
`else
  // Goal pulse without lockout: every debounced beam block scores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      goal_q <= 1'b0;
    end else begin
      goal_q <= rise[2];
    end
  end

  assign bus.goal_busy = 1'b0;
`endif

  assign bus.start        = start_q;
  assign bus.stop         = stop_q;
  assign bus.goal         = goal_q;
  assign bus.beam_blocked = deb_level[2];

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed scenarios with a pulse scoreboard.
// Stimulus pushes each expected pulse (cycle and which outputs) into a queue;
// an independent monitor pops and compares whenever any pulse output is high.
module tb_input_conditioner;

  localparam int DEB  = 4;
  localparam int LOCK = 20;
`ifdef GOAL_LOCKOUT_EN
  localparam logic BUSY = 1'b1;
`else
  localparam logic BUSY = 1'b0;
`endif

  typedef struct {
    int   at;
    logic s;
    logic p;
    logic g;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   fails;
  int   base;
  ev_t  exp_q[$];

  input_conditioner_if bus ();

  input_conditioner #(
    .DEB_CYCLES     (DEB),
    .LOCKOUT_CYCLES (LOCK),
    .CNT_W          (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 100 MHz clock and a free-running edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic s, input logic p, input logic sn);
    bus.btn_start = s;
    bus.btn_stop  = p;
    bus.sensor_n  = sn;
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, actual, expected);
    end
  endtask

  task automatic expectPulse(input int at, input logic s, input logic p, input logic g);
    ev_t e;
    e.at = at;
    e.s  = s;
    e.p  = p;
    e.g  = g;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cycle with a pulse must match the next expected event
  always @(negedge clk) begin
    ev_t e;
    if (bus.start || bus.stop || bus.goal) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected pulse at cycle %0d: start/stop/goal=%b%b%b, expected none",
                 cyc, bus.start, bus.stop, bus.goal);
      end else begin
        e = exp_q.pop_front();
        if (e.at != cyc || e.s !== bus.start || e.p !== bus.stop || e.g !== bus.goal) begin
          fails++;
          $display("[TB] FAIL pulse: got cycle %0d start/stop/goal=%b%b%b, expected cycle %0d %b%b%b",
                   cyc, bus.start, bus.stop, bus.goal, e.at, e.s, e.p, e.g);
        end
      end
    end
  end

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(3);
    checkOutput("reset start", bus.start, 1'b0);
    checkOutput("reset stop", bus.stop, 1'b0);
    checkOutput("reset goal", bus.goal, 1'b0);
    checkOutput("reset goal_busy", bus.goal_busy, 1'b0);
    checkOutput("reset beam_blocked", bus.beam_blocked, 1'b0);
    rst = 1'b0;
    tick(5);

    $display("[TB] clean press");
    applyStimulus(1'b1, 1'b0, 1'b1);
    expectPulse(cyc + DEB + 3, 1'b1, 1'b0, 1'b0);
    tick(50);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(12);

    $display("[TB] bounce reject");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, (i % 2) == 0, 1'b1);
      tick(2);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(12);

    $display("[TB] goal plus lockout");
    base = cyc;
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectPulse(base + 7, 1'b0, 1'b0, 1'b1);
    tick(6);
    checkOutput("beam_blocked before goal", bus.beam_blocked, 1'b1);
    checkOutput("goal_busy idle before goal", bus.goal_busy, 1'b0);
    tick(1);
    checkOutput("goal_busy with goal", bus.goal_busy, BUSY);
    tick(3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(8);
    applyStimulus(1'b0, 1'b0, 1'b0);
`ifndef GOAL_LOCKOUT_EN
    expectPulse(base + 25, 1'b0, 1'b0, 1'b1);
`endif
    tick(8);
    checkOutput("goal_busy last window cycle", bus.goal_busy, BUSY);
    checkOutput("beam_blocked second block", bus.beam_blocked, 1'b1);
    tick(1);
    checkOutput("goal_busy after window", bus.goal_busy, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectPulse(base + 43, 1'b0, 1'b0, 1'b1);
    tick(10);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(30);

    $display("[TB] simultaneous events");
    base = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0);
    expectPulse(base + 7, 1'b1, 1'b1, 1'b1);
    tick(10);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(32);
    checkOutput("beam released", bus.beam_blocked, 1'b0);

    $display("[TB] reset mid-lockout");
    base = cyc;
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectPulse(base + 7, 1'b0, 1'b0, 1'b1);
    tick(12);
    checkOutput("goal_busy inside window", bus.goal_busy, BUSY);
    rst = 1'b1;
    #1;
    checkOutput("goal_busy on reset", bus.goal_busy, 1'b0);
    checkOutput("beam_blocked on reset", bus.beam_blocked, 1'b0);
    tick(3);
    checkOutput("goal during reset", bus.goal, 1'b0);
    checkOutput("start during reset", bus.start, 1'b0);
    rst = 1'b0;
    expectPulse(cyc + DEB + 3, 1'b0, 1'b0, 1'b1);
    tick(6);
    checkOutput("beam_blocked after reset", bus.beam_blocked, 1'b1);
    tick(1);
    checkOutput("goal_busy after reset goal", bus.goal_busy, BUSY);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(30);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL missing pulses: got %0d still pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
